// File: rtl/wb_gpio_irq_pkg.sv
// Shared register offsets, register selects and helpers for the Wishbone GPIO block.
package wb_gpio_irq_pkg;

    localparam logic [5:0] GPIO_IN     = 6'h00;
    localparam logic [5:0] GPIO_OUT    = 6'h04;
    localparam logic [5:0] GPIO_DIR    = 6'h08;
    localparam logic [5:0] GPIO_SET    = 6'h0C;
    localparam logic [5:0] GPIO_CLR    = 6'h10;
    localparam logic [5:0] GPIO_TGL    = 6'h14;
    localparam logic [5:0] GPIO_IRQ_EN = 6'h18;
    localparam logic [5:0] GPIO_RISE   = 6'h1C;
    localparam logic [5:0] GPIO_FALL   = 6'h20;
    localparam logic [5:0] GPIO_STATUS = 6'h24;

    typedef enum logic [3:0] {
        SEL_IN,
        SEL_OUT,
        SEL_DIR,
        SEL_SET,
        SEL_CLR,
        SEL_TGL,
        SEL_IRQ_EN,
        SEL_RISE,
        SEL_FALL,
        SEL_STATUS,
        SEL_NONE
    } regSelE;

    // Unaligned or unmapped offsets fall into SEL_NONE (reads 0, writes ignored).
    function automatic regSelE decodeReg(input logic [5:0] adr);
        case (adr)
            GPIO_IN:     return SEL_IN;
            GPIO_OUT:    return SEL_OUT;
            GPIO_DIR:    return SEL_DIR;
            GPIO_SET:    return SEL_SET;
            GPIO_CLR:    return SEL_CLR;
            GPIO_TGL:    return SEL_TGL;
            GPIO_IRQ_EN: return SEL_IRQ_EN;
            GPIO_RISE:   return SEL_RISE;
            GPIO_FALL:   return SEL_FALL;
            GPIO_STATUS: return SEL_STATUS;
            default:     return SEL_NONE;
        endcase
    endfunction

    // Expands the four byte enables into a 32-bit bit mask.
    function automatic logic [31:0] byteMask(input logic [3:0] sel);
        return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
    endfunction

endpackage

// File: rtl/wb_if.sv
// Wishbone pipelined bus bundle shared by the SoC crossbar and its slaves.
interface wb_if;
    logic [31:0] adr;
    logic [31:0] dat_m;
    logic [31:0] dat_s;
    logic [3:0]  sel;
    logic        we;
    logic        cyc;
    logic        stb;
    logic        ack;
    logic        stall;
    logic        err;

    modport master (output adr, dat_m, sel, we, cyc, stb, input dat_s, ack, stall, err);
    modport slave  (input adr, dat_m, sel, we, cyc, stb, output dat_s, ack, stall, err);
endinterface

// File: rtl/gpio_sync.sv
// Multi-flop synchronizer for the pad inputs, one chain per bit.
module gpio_sync #(
    parameter int width  = 32,
    parameter int stages = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [width-1:0] d_i,
    output logic [width-1:0] q_o
);

    logic [width-1:0] stage_q [stages];

    // Shift the pad value through the chain; everything clears to 0 on reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int s = 0; s < stages; s++) begin
                stage_q[s] <= '0;
            end
        end else begin
            stage_q[0] <= d_i;
            for (int s = 1; s < stages; s++) begin
                stage_q[s] <= stage_q[s-1];
            end
        end
    end

    assign q_o = stage_q[stages-1];

endmodule

// File: rtl/wb_gpio_irq.sv
// Wishbone GPIO slave with tristate pads, atomic output writes and edge interrupts.
module wb_gpio_irq
    import wb_gpio_irq_pkg::*;
#(
    parameter int              size        = 32,
    parameter int              sync_stages = 2,
    parameter logic [size-1:0] out_rst     = '0,
    parameter logic [size-1:0] dir_rst     = '0
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    inout  wire  [size-1:0] gpio,
    wb_if.slave             wb,
    output logic            irq
);

    logic [size-1:0] out_q, out_d;
    logic [size-1:0] dir_q, dir_d;
    logic [size-1:0] irqEn_q, irqEn_d;
    logic [size-1:0] riseEn_q, riseEn_d;
    logic [size-1:0] fallEn_q, fallEn_d;
    logic [size-1:0] status_q, status_d;
    logic [size-1:0] prev_q;
    logic [size-1:0] syncIn;
    logic [size-1:0] hwSet;
    logic [size-1:0] wrMask;
    logic [size-1:0] wrData;
    logic [31:0]     wrMask32;
    logic [31:0]     rdMux;
    logic [31:0]     rdData_q;
    logic            ack_q;
    logic            reqValid;
    logic            wrEn;
    regSelE          regSel;
    logic            unusedAdr;

    assign reqValid = wb.cyc && wb.stb;
    assign wrEn     = reqValid && wb.we;
    assign regSel   = decodeReg(wb.adr[5:0]);
    assign wrMask32 = byteMask(wb.sel);
    assign wrMask   = wrMask32[size-1:0];
    assign wrData   = wb.dat_m[size-1:0] & wrMask;

    assign unusedAdr = ^wb.adr[31:6];

    assign wb.stall = 1'b0;
    assign wb.err   = 1'b0;
    assign wb.ack   = ack_q;
    assign wb.dat_s = rdData_q;

    gpio_sync #(
        .width  (size),
        .stages (sync_stages)
    ) u_sync (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .d_i    (gpio),
        .q_o    (syncIn)
    );

    // Each pad is driven only while its direction bit selects output.
    for (genvar i = 0; i < size; i++) begin : gPad
        assign gpio[i] = dir_q[i] ? out_q[i] : 1'bz;
    end

    // Edge detection uses the current DIR so an input->output switch never flags an edge.
    assign hwSet = ~dir_q & ((syncIn & ~prev_q & riseEn_q) | (~syncIn & prev_q & fallEn_q));

    assign irq = |(status_q & irqEn_q);

    // Register next-state: bus writes first, then hardware STATUS sets override W1C.
    always_comb begin
        out_d    = out_q;
        dir_d    = dir_q;
        irqEn_d  = irqEn_q;
        riseEn_d = riseEn_q;
        fallEn_d = fallEn_q;
        status_d = status_q;
        if (wrEn) begin
            case (regSel)
                SEL_OUT:    out_d    = (out_q & ~wrMask) | wrData;
                SEL_DIR:    dir_d    = (dir_q & ~wrMask) | wrData;
                SEL_SET:    out_d    = out_q | wrData;
                SEL_CLR:    out_d    = out_q & ~wrData;
                SEL_TGL:    out_d    = out_q ^ wrData;
                SEL_IRQ_EN: irqEn_d  = (irqEn_q & ~wrMask) | wrData;
                SEL_RISE:   riseEn_d = (riseEn_q & ~wrMask) | wrData;
                SEL_FALL:   fallEn_d = (fallEn_q & ~wrMask) | wrData;
                SEL_STATUS: status_d = status_q & ~wrData;
                default:    ;
            endcase
        end
        status_d = status_d | hwSet;
    end

    // Read multiplexer; write-only and unmapped offsets return 0.
    always_comb begin
        rdMux = '0;
        case (regSel)
            SEL_IN:     rdMux = 32'(syncIn);
            SEL_OUT:    rdMux = 32'(out_q);
            SEL_DIR:    rdMux = 32'(dir_q);
            SEL_IRQ_EN: rdMux = 32'(irqEn_q);
            SEL_RISE:   rdMux = 32'(riseEn_q);
            SEL_FALL:   rdMux = 32'(fallEn_q);
            SEL_STATUS: rdMux = 32'(status_q);
            default:    rdMux = '0;
        endcase
    end

    // Register state, the one-cycle ack and the held read data.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_q    <= out_rst;
            dir_q    <= dir_rst;
            irqEn_q  <= '0;
            riseEn_q <= '0;
            fallEn_q <= '0;
            status_q <= '0;
            prev_q   <= '0;
            ack_q    <= 1'b0;
            rdData_q <= '0;
        end else begin
            out_q    <= out_d;
            dir_q    <= dir_d;
            irqEn_q  <= irqEn_d;
            riseEn_q <= riseEn_d;
            fallEn_q <= fallEn_d;
            status_q <= status_d;
            prev_q   <= syncIn;
            ack_q    <= reqValid;
            if (reqValid && !wb.we) begin
                rdData_q <= rdMux;
            end
        end
    end

endmodule

// File: tb/tb_wb_gpio_irq.sv
// Directed self-checking bench for wb_gpio_irq with a queue of expected bus responses.
module tb_wb_gpio_irq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        irq;
    logic [31:0] padEn;
    logic [31:0] padVal;
    wire  [31:0] gpio;
    int          nAsserts = 0;
    int          nFails   = 0;

    typedef struct {
        logic        isRead;
        logic [31:0] exp;
        string       tag;
    } pendT;

    pendT pendQ[$];

    wb_if wb ();

    always #5 clk = ~clk;

    // The bench plays the external world: it drives every pad the DUT is not driving.
    for (genvar i = 0; i < 32; i++) begin : gDrv
        assign gpio[i] = padEn[i] ? padVal[i] : 1'bz;
    end

    wb_gpio_irq #(
        .size        (32),
        .sync_stages (2)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .gpio   (gpio),
        .wb     (wb),
        .irq    (irq)
    );

    task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nAsserts++;
        assert (obs === exp)
        else begin
            nFails++;
            $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge: the oldest pending request must be acked now, otherwise ack must be low.
    task automatic checkOutput();
        pendT e;
        if (pendQ.size() > 0) begin
            e = pendQ.pop_front();
            checkEq({e.tag, " ack"}, {31'b0, wb.ack}, 32'd1);
            if (e.isRead) begin
                checkEq(e.tag, wb.dat_s, e.exp);
            end
        end else begin
            checkEq("idle ack", {31'b0, wb.ack}, 32'd0);
        end
    endtask

    // Drives one request at a falling edge and checks its response at the next one.
    task automatic applyStimulus(input logic we, input logic [5:0] adr, input logic [31:0] dat,
                                 input logic [3:0] sel, input logic [31:0] expRead, input string tag);
        pendT e;
        wb.cyc   = 1'b1;
        wb.stb   = 1'b1;
        wb.we    = we;
        wb.adr   = {26'h0, adr};
        wb.dat_m = dat;
        wb.sel   = sel;
        e.isRead = !we;
        e.exp    = expRead;
        e.tag    = tag;
        pendQ.push_back(e);
        @(negedge clk);
        checkOutput();
    endtask

    task automatic idle();
        wb.cyc = 1'b0;
        wb.stb = 1'b0;
        wb.we  = 1'b0;
        @(negedge clk);
        checkOutput();
    endtask

    task automatic wr(input logic [5:0] adr, input logic [31:0] dat, input logic [3:0] sel);
        applyStimulus(1'b1, adr, dat, sel, 32'h0, $sformatf("wr@%02h", adr));
    endtask

    task automatic rd(input logic [5:0] adr, input logic [31:0] exp, input string tag);
        applyStimulus(1'b0, adr, 32'h0, 4'hF, exp, tag);
    endtask

    task automatic checkIrq(input string tag, input logic exp);
        checkEq(tag, {31'b0, irq}, {31'b0, exp});
    endtask

    initial begin
        rst_n    = 1'b1;
        padEn    = '1;
        padVal   = '0;
        wb.cyc   = 1'b0;
        wb.stb   = 1'b0;
        wb.we    = 1'b0;
        wb.adr   = '0;
        wb.dat_m = '0;
        wb.sel   = 4'h0;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checkEq("ack in reset", {31'b0, wb.ack}, 32'd0);
        checkIrq("irq in reset", 1'b0);
        rst_n = 1'b1;
        repeat (3) idle();

        $display("[TB] reset values");
        rd(6'h00, 32'h0, "IN rst");
        rd(6'h04, 32'h0, "OUT rst");
        rd(6'h08, 32'h0, "DIR rst");
        rd(6'h0C, 32'h0, "SET rst");
        rd(6'h10, 32'h0, "CLR rst");
        rd(6'h14, 32'h0, "TGL rst");
        rd(6'h18, 32'h0, "IRQ_EN rst");
        rd(6'h1C, 32'h0, "RISE rst");
        rd(6'h20, 32'h0, "FALL rst");
        rd(6'h24, 32'h0, "STATUS rst");
        rd(6'h28, 32'h0, "unmapped rst");
        idle();
        checkIrq("irq after reset", 1'b0);

        $display("[TB] output writes");
        padEn = ~32'h0000_00FF;
        wr(6'h08, 32'h0000_00FF, 4'hF);
        wr(6'h04, 32'h0000_00A5, 4'hF);
        wr(6'h0C, 32'h0000_0100, 4'hF);
        wr(6'h10, 32'h0000_0001, 4'hF);
        wr(6'h14, 32'h0000_00F0, 4'hF);
        checkEq("pads[7:0]", {24'h0, gpio[7:0]}, 32'h0000_0054);
        rd(6'h04, 32'h0000_0154, "OUT atomic");
        rd(6'h0C, 32'h0, "SET reads 0");
        repeat (3) idle();
        rd(6'h00, 32'h0000_0054, "IN readback");

        $display("[TB] byte lanes");
        wr(6'h04, 32'h0, 4'hF);
        wr(6'h04, 32'hFFFF_FFFF, 4'b0010);
        rd(6'h04, 32'h0000_FF00, "OUT lane1");
        wr(6'h0C, 32'hFFFF_FFFF, 4'b0001);
        rd(6'h04, 32'h0000_FFFF, "SET lane0");

        $display("[TB] rising edge interrupt");
        padEn = '1;
        wr(6'h08, 32'h0, 4'hF);
        repeat (4) idle();
        rd(6'h24, 32'h0, "STATUS quiet");
        wr(6'h18, 32'h0000_1000, 4'hF);
        wr(6'h1C, 32'h0000_1000, 4'hF);
        padVal[12] = 1'b1;
        idle();
        checkIrq("irq rise +1", 1'b0);
        idle();
        checkIrq("irq rise +2", 1'b0);
        idle();
        checkIrq("irq rise +3", 1'b1);
        rd(6'h24, 32'h0000_1000, "STATUS rise");
        wr(6'h24, 32'h0000_1000, 4'hF);
        checkIrq("irq after W1C", 1'b0);
        padVal[12] = 1'b0;
        repeat (4) idle();
        rd(6'h24, 32'h0, "STATUS fall ignored");
        checkIrq("irq fall ignored", 1'b0);

        $display("[TB] set beats W1C");
        wr(6'h20, 32'h0000_0008, 4'hF);
        padVal[3] = 1'b1;
        repeat (4) idle();
        rd(6'h24, 32'h0, "STATUS rise3 ignored");
        padVal[3] = 1'b0;
        idle();
        idle();
        wr(6'h24, 32'h0000_0008, 4'hF);
        rd(6'h24, 32'h0000_0008, "STATUS set wins");
        checkIrq("irq masked bit3", 1'b0);
        wr(6'h24, 32'h0000_0008, 4'hF);
        rd(6'h24, 32'h0, "STATUS cleared");

        $display("[TB] back-to-back reads");
        rd(6'h04, 32'h0000_FFFF, "burst OUT");
        rd(6'h18, 32'h0000_1000, "burst IRQ_EN");
        rd(6'h1C, 32'h0000_1000, "burst RISE");
        rd(6'h20, 32'h0000_0008, "burst FALL");
        idle();

        $display("[TB] reset mid-burst");
        rd(6'h04, 32'h0000_FFFF, "pre-rst OUT");
        rd(6'h18, 32'h0000_1000, "pre-rst IRQ_EN");
        wb.adr = {26'h0, 6'h20};
        #2 rst_n = 1'b0;
        #1;
        checkEq("ack async clear", {31'b0, wb.ack}, 32'd0);
        checkEq("rdata async clear", wb.dat_s, 32'h0);
        @(negedge clk);
        checkEq("ack held in reset", {31'b0, wb.ack}, 32'd0);
        pendQ.delete();
        wb.cyc = 1'b0;
        wb.stb = 1'b0;
        rst_n  = 1'b1;
        repeat (3) idle();
        rd(6'h04, 32'h0, "OUT post-rst");
        rd(6'h18, 32'h0, "IRQ_EN post-rst");
        rd(6'h20, 32'h0, "FALL post-rst");
        rd(6'h24, 32'h0, "STATUS post-rst");
        idle();
        checkIrq("irq post-rst", 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
        $finish;
    end

endmodule

// File: doc/wb_gpio_irq.md
Name: wb_gpio_irq

Overview:
- Second-generation Wishbone GPIO slave: per-bit tristate pins with direction control.
- Adds a configurable input synchronizer, atomic set/clear/toggle output writes, byte-lane writes, and per-bit edge-detect interrupts with W1C status.
- Sits on the SoC Wishbone crossbar beside the UART and timer; its irq output feeds the Ibex fast-interrupt input.

Parameters:
- size, 32, number of GPIO bits (1..32); bits above size read 0 and ignore writes.
- sync_stages, 2, flip-flop stages on each pad input (>=2).
- out_rst, '0, reset value of OUT.
- dir_rst, '0, reset value of DIR (1 = output).

Ports:
- clk_i  input  1  block clock; the Wishbone interface is synchronous to it.
- rst_ni  input  1  asynchronous active-low reset; wb.rst is not used.
- gpio  inout  size  pads; bit i is driven with OUT[i] when DIR[i]=1, otherwise high-Z.
- wb  wb_if.slave  -  Wishbone pipelined slave: adr, dat_m/dat_i, dat_s/dat_o, sel, we, cyc, stb, ack, stall, err.
- irq  output  1  level interrupt: |(STATUS & IRQ_EN).

Behaviour:
- Register map, decoded on wb.adr[5:0]; word-aligned, 32-bit:
  - 0x00 IN: read-only, synchronized pad value for all bits, including outputs (read-back).
  - 0x04 OUT: read/write.
  - 0x08 DIR: read/write.
  - 0x0C OUT_SET: write-only, W1S on OUT; reads 0.
  - 0x10 OUT_CLR: write-only, W1C on OUT; reads 0.
  - 0x14 OUT_TGL: write-only, W1 toggles OUT; reads 0.
  - 0x18 IRQ_EN: read/write.
  - 0x1C RISE_EN: read/write.
  - 0x20 FALL_EN: read/write.
  - 0x24 STATUS: read, W1C.
  - Other offsets: reads 0, writes ignored.
- Byte enables:
  - wb.sel[k] gates byte k on every write, including the W1x registers.
  - Reads ignore sel.
- Handshake:
  - stall = 0 and err = 0, constant.
  - A request is valid when cyc && stb.
  - ack is asserted exactly one cycle after each valid request, so back-to-back strobes give back-to-back acks.
  - ack is 0 in any cycle that does not follow a valid request.
  - Read data is registered in the same edge as ack and holds its value until the next read.
- Input path:
  - Pad goes through sync_stages flops, then one extra flop (prev) for edge detection.
  - IN reflects a pad change sync_stages cycles after it.
- Edge detection, per bit i, only while DIR[i]=0:
  - rise = sync[i] & ~prev[i]; fall = ~sync[i] & prev[i].
  - STATUS[i] is set when (rise & RISE_EN[i]) | (fall & FALL_EN[i]).
  - An edge is detected 1 cycle after it appears in IN.
- STATUS update order:
  - If the same bit gets a hardware set and a W1C in the same cycle, the set wins and STATUS stays 1.
  - STATUS bits whose IRQ_EN is 0 still latch; only irq is masked.
- irq is combinational from STATUS and IRQ_EN; it rises the cycle after the STATUS bit sets.
- Output update:
  - OUT writes take effect on the edge that registers ack.
  - Pads change in that same cycle.
- Direction change:
  - Setting DIR[i] 0->1 does not generate edges, because detection is gated by the new DIR value.
  - The sync/prev flops keep running.
- Reset (rst_ni low, asynchronous):
  - OUT=out_rst, DIR=dir_rst, IRQ_EN=RISE_EN=FALL_EN=STATUS=0.
  - Sync and prev flops = 0; ack=0; read data=0; irq=0.
  - A transaction in flight during reset is dropped with no ack.
- After reset deassertion:
  - The sync chain fills from 0.
  - A pad held high at reset produces a rising edge only if RISE_EN is already 1 by the time it reaches prev.
  - Firmware is required to clear STATUS after enabling.

Decomposition:
- Package wb_gpio_irq_pkg holds:
  - localparam offsets: GPIO_IN, GPIO_OUT, GPIO_DIR, GPIO_SET, GPIO_CLR, GPIO_TGL, GPIO_IRQ_EN, GPIO_RISE, GPIO_FALL, GPIO_STATUS.
  - typedef enum of register selects.
- Sub-module gpio_sync #(width, stages): multi-flop synchronizer with async active-low reset, instantiated once for the whole vector.

Test Plan:
- Reset then read all offsets -> IN=0 (pads pulled low); OUT=out_rst; DIR=dir_rst; others 0; irq=0; each read acked exactly 1 cycle after stb.
- Write DIR=0x0000_00FF, OUT=0xA5, then OUT_SET=0x100, OUT_CLR=0x01, OUT_TGL=0xF0 -> OUT=0x0000_0154; pads[7:0]=0x54; pad 8 high-Z; IN[7:0]=0x54.
- Byte-lane write OUT=0xFFFF_FFFF with sel=4'b0010 from OUT=0 -> OUT=0x0000_FF00.
- Enable IRQ_EN=RISE_EN=0x1000, drive pad 12 low->high -> STATUS=0x1000 sync_stages+1 cycles later; irq=1; W1C 0x1000 -> irq=0; a falling edge leaves STATUS=0.
- Set FALL_EN bit 3, then drive a falling edge on pad 3 in the same cycle as a W1C of bit 3 -> STATUS[3] stays 1.
- Issue 4 back-to-back read strobes, and separately pulse rst_ni low mid-burst -> without reset, 4 consecutive acks with correct data; with reset, ack drops to 0 asynchronously and registers return to reset values.
